// File: rtl/sar_step_controller.sv
// SAR conversion sequencer: sample, MSB->LSB binary search on DacCode, Done/Result.
// Optional IDLE +/-1 tracking of the input is built when SAR_TRACK_EN is defined.
module sar_step_controller #(
  parameter int BITS       = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE     = 2
) (
  input  logic            ClockT,
  input  logic            Reset,
  input  logic            Start,
  input  logic            CompIn,
  input  logic            TrackEn,
  output logic [1:0]      StateP,
  output logic            Inc,
  output logic            Dcr,
  output logic            SampleHold,
  output logic [BITS-1:0] DacCode,
  output logic [BITS-1:0] Result,
  output logic            Done,
  output logic            Busy
);

  localparam int CNT_MAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(BITS - 1);
  localparam logic [BITS-1:0]  CODE_MSB    = BITS'(1) << (BITS - 1);
  localparam logic [BITS-1:0]  CODE_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAMPLE  = 2'b01,
    CONVERT = 2'b10,
    DONE    = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BITS-1:0]  dac_q, dac_d;
  logic [BITS-1:0]  result_q, result_d;
  logic [BITS-1:0]  trial_code;
  logic             inc_q, inc_d, dcr_q, dcr_d;
  logic             done_q, done_d, sh_q, sh_d, busy_q, busy_d;

`ifndef SAR_TRACK_EN
  logic unused_track_en;
  assign unused_track_en = TrackEn;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    dac_d      = dac_q;
    result_d   = result_q;
    trial_code = dac_q;
    inc_d      = 1'b0;
    dcr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Start) begin
          state_d = SAMPLE;
        end else begin
`ifdef SAR_TRACK_EN
          // Step counter only runs while tracking; one +/-1 step per SETTLE cycles.
          if (TrackEn) begin
            if (cnt_q == SETTLE_LAST) begin
              if (CompIn && (dac_q != CODE_MAX)) begin
                dac_d = dac_q + 1'b1;
                inc_d = 1'b1;
              end else if (!CompIn && (dac_q != '0)) begin
                dac_d = dac_q - 1'b1;
                dcr_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`endif
        end
      end

      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = CONVERT;
          cnt_d   = '0;
          bit_d   = MSB_IDX;
          dac_d   = CODE_MSB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CONVERT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          // Resolve the current bit and arm the next trial bit in one update.
          if (!CompIn) trial_code[bit_q] = 1'b0;
          if (bit_q != '0) trial_code[bit_q - 1'b1] = 1'b1;
          dac_d = trial_code;
          if (bit_q == '0) begin
            state_d  = DONE;
            result_d = trial_code;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sh_d   = (state_d == SAMPLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      inc_q    <= 1'b0;
      dcr_q    <= 1'b0;
      done_q   <= 1'b0;
      sh_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      inc_q    <= inc_d;
      dcr_q    <= dcr_d;
      done_q   <= done_d;
      sh_q     <= sh_d;
      busy_q   <= busy_d;
    end
  end

  assign StateP     = state_q;
  assign Inc        = inc_q;
  assign Dcr        = dcr_q;
  assign SampleHold = sh_q;
  assign DacCode    = dac_q;
  assign Result     = result_q;
  assign Done       = done_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_sar_step_controller.sv
// Bench for sar_step_controller: ideal comparator against a random/directed Vin,
// expected timeline derived from the conversion rules with plain arithmetic.
module tb_sar_step_controller;

  localparam int BITS       = 8;
  localparam int SAMPLE_CYC = 4;
  localparam int SETTLE     = 2;
  localparam int CONV_CYC   = BITS * SETTLE;
  localparam int DONE_T     = 1 + SAMPLE_CYC + CONV_CYC;
`ifdef SAR_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            track_en;
  logic            comp_in;
  logic [1:0]      state_p;
  logic            inc, dcr, sample_hold, done, busy;
  logic [BITS-1:0] dac_code, result;
  logic [BITS-1:0] vin;

  int checks = 0;
  int errors = 0;
  int code_m = 0;
  int result_m = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  assign comp_in = (vin >= dac_code);

  sar_step_controller #(.BITS(BITS), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE(SETTLE)) dut (
    .ClockT(clk), .Reset(rst), .Start(start), .CompIn(comp_in), .TrackEn(track_en),
    .StateP(state_p), .Inc(inc), .Dcr(dcr), .SampleHold(sample_hold),
    .DacCode(dac_code), .Result(result), .Done(done), .Busy(busy)
  );

  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int dac, input int res,
                           input bit dn, input bit up, input bit down);
    check({tag, ".state"}, 32'(state_p), 32'(st));
    check({tag, ".dac"}, 32'(dac_code), 32'(dac));
    check({tag, ".result"}, 32'(result), 32'(res));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".hold"}, 32'(sample_hold), 32'(st == 1));
    check({tag, ".busy"}, 32'(busy), 32'(st != 0));
    check({tag, ".inc"}, 32'(inc), 32'(up));
    check({tag, ".dcr"}, 32'(dcr), 32'(down));
  endtask

  // Caller is at a falling edge with the DUT in IDLE; t counts cycles after Start is taken.
  task automatic conv(input int v, input bit hold);
    int st, dac, res, b, j;
    vin   = v[BITS-1:0];
    start = 1'b1;
    for (int t = 1; t <= DONE_T + 1; t++) begin
      @(negedge clk);
      if (!hold && t == 1) start = 1'b0;
      res = result_m;
      if (t <= SAMPLE_CYC) begin
        st = 1; dac = code_m;
      end else if (t < DONE_T) begin
        j   = t - SAMPLE_CYC - 1;
        b   = BITS - 1 - j / SETTLE;
        st  = 2;
        dac = ((v >> (b + 1)) << (b + 1)) | (1 << b);
      end else begin
        st  = (t == DONE_T) ? 3 : 0;
        dac = v;
        res = v;
      end
      check_all($sformatf("conv%02h.t%0d", v, t), st, dac, res, (t == DONE_T), 1'b0, 1'b0);
    end
    code_m   = v;
    result_m = v;
  endtask

  task automatic track(input int v, input int ncyc);
    bit up, down;
    vin      = v[BITS-1:0];
    track_en = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      up = 1'b0; down = 1'b0;
      if (TRACK && (i % SETTLE == 0)) begin
        if (v >= code_m && code_m < (1 << BITS) - 1) begin
          code_m++; up = 1'b1;
        end else if (v < code_m && code_m > 0) begin
          code_m--; down = 1'b1;
        end
      end
      check_all($sformatf("track%02h.i%0d", v, i), 0, code_m, result_m, 1'b0, up, down);
    end
    track_en = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; track_en = 1'b0; vin = '0;
    repeat (2) @(negedge clk);
    check_all("in_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_all("after_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    conv(8'hA5, 1'b0);
    track(8'hA7, 12);
    conv(8'hFF, 1'b0);
    track(8'hFF, 8);
    conv(8'h00, 1'b0);
    track(8'h00, 6);

    // Reset in the middle of CONVERT aborts with no Done.
    vin = 8'($urandom_range(0, 255));
    start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    d0 = done_seen;
    #2 rst = 1'b1;
    #1 check_all("async_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    code_m = 0; result_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all($sformatf("post_abort.%0d", i), 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    conv(int'($urandom_range(0, 255)), 1'b0);

    // Start held high: one Done per conversion, restart only from IDLE.
    d0 = done_seen;
    conv(int'($urandom_range(0, 255)), 1'b1);
    check("held_one_done", 32'(done_seen - d0), 32'd1);
    conv(int'($urandom_range(0, 255)), 1'b0);
    check("held_two_done", 32'(done_seen - d0), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all($sformatf("held_idle.%0d", i), 0, code_m, result_m, 1'b0, 1'b0, 1'b0);
    end

    for (int n = 0; n < 4; n++) begin
      conv(int'($urandom_range(0, 255)), 1'b0);
      track(int'($urandom_range(0, 255)), 2 * SETTLE + n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
